// File: rtl/aes_arbiter_if.sv
// Client/core bundle of the two-requester AES scheduler; slave = arbiter, master = clients plus core.
// No storage: wiring and direction only.
// Backpressure: clients hold requests until ack; the core owns completion timing.
interface aes_arbiter_if;
  logic         i_fReq0;
  logic         i_fReq1;
  logic         i_fEnc0;
  logic         i_fEnc1;
  logic [127:0] i_Text0;
  logic [127:0] i_Text1;
  logic [127:0] i_Key0;
  logic [127:0] i_Key1;
  logic         o_fAck0;
  logic         o_fAck1;
  logic         o_fValid0;
  logic         o_fValid1;
  logic         o_fErr;
  logic [127:0] o_Data;
  logic         o_fStart;
  logic         o_fEncrypt;
  logic [127:0] o_Text;
  logic [127:0] o_Key;
  logic [127:0] i_CoreData;
  logic         i_fCoreDone;
  logic         o_CoreRst_n;

  modport slave (
    input  i_fReq0, i_fReq1, i_fEnc0, i_fEnc1, i_Text0, i_Text1, i_Key0, i_Key1,
    input  i_CoreData, i_fCoreDone,
    output o_fAck0, o_fAck1, o_fValid0, o_fValid1, o_fErr, o_Data,
    output o_fStart, o_fEncrypt, o_Text, o_Key, o_CoreRst_n
  );

  modport master (
    output i_fReq0, i_fReq1, i_fEnc0, i_fEnc1, i_Text0, i_Text1, i_Key0, i_Key1,
    output i_CoreData, i_fCoreDone,
    input  o_fAck0, o_fAck1, o_fValid0, o_fValid1, o_fErr, o_Data,
    input  o_fStart, o_fEncrypt, o_Text, o_Key, o_CoreRst_n
  );
endinterface

// File: rtl/aes_arbiter.sv
// Round-robin scheduler of two clients onto one iterative AES core; optional BUSY watchdog via AES_ARB_TIMEOUT_EN.
// Latency: ack 1 cycle after request, valid 1 cycle after core done; jobs cost core latency + 3 cycles.
// Backpressure: requests are only sampled in IDLE, so clients hold them until ack.
module aes_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  aes_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RESP} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last;
  logic         r_gnt;
  logic         r_enc;
  logic [127:0] r_text;
  logic [127:0] r_key;
  logic [127:0] r_data;
  logic         w_any_req;
  logic         w_gnt;
  logic         w_done;
  logic         w_tmo;

  assign w_any_req = bus.i_fReq0 | bus.i_fReq1;
  // On a tie the client that did not win last time goes; a lone requester always wins.
  assign w_gnt     = (bus.i_fReq0 & bus.i_fReq1) ? ~r_last : bus.i_fReq1;
  assign w_done    = (r_state == ST_BUSY) & bus.i_fCoreDone;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Done on the same edge as expiry takes priority, so expiry requires no done.
  assign w_tmo = (r_state == ST_BUSY) & ~bus.i_fCoreDone & (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUSY && w_state_nxt == ST_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_err <= 1'b0;
    end else if (w_done) begin
      r_err <= 1'b0;
    end else if (w_tmo) begin
      r_err <= 1'b1;
    end
  end

  assign bus.o_fErr      = r_err;
  assign bus.o_CoreRst_n = ~((r_state == ST_RESP) & r_err);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_tmo            = 1'b0;
  assign bus.o_fErr       = 1'b0;
  assign bus.o_CoreRst_n  = 1'b1;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_BUSY;
      ST_BUSY:  if (w_done || w_tmo) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Core-side operands change only on a grant, which keeps them frozen through BUSY.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_last <= 1'b1;
      r_gnt  <= 1'b0;
      r_enc  <= 1'b0;
      r_text <= '0;
      r_key  <= '0;
      r_data <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_last <= w_gnt;
        r_gnt  <= w_gnt;
        r_enc  <= w_gnt ? bus.i_fEnc1  : bus.i_fEnc0;
        r_text <= w_gnt ? bus.i_Text1  : bus.i_Text0;
        r_key  <= w_gnt ? bus.i_Key1   : bus.i_Key0;
      end
      if (w_done) begin
        r_data <= bus.i_CoreData;
      end else if (w_tmo) begin
        r_data <= '0;
      end
    end
  end

  assign bus.o_fStart   = (r_state == ST_ISSUE);
  assign bus.o_fAck0    = (r_state == ST_ISSUE) & ~r_gnt;
  assign bus.o_fAck1    = (r_state == ST_ISSUE) &  r_gnt;
  assign bus.o_fValid0  = (r_state == ST_RESP)  & ~r_gnt;
  assign bus.o_fValid1  = (r_state == ST_RESP)  &  r_gnt;
  assign bus.o_fEncrypt = r_enc;
  assign bus.o_Text     = r_text;
  assign bus.o_Key      = r_key;
  assign bus.o_Data     = r_data;

endmodule
